dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the core's load/store path and a debug/loader port. It sits between the core's LSU and `data_memory`. It grants at most one request per cycle and routes the one-cycle-latency memory response back to the requester that issued it. Core traffic has priority; an optional starvation guard bounds the debug port's wait.

## Interface
Parameters:
- `XLEN`, 32: data width (from `rv32i_pkg`).
- `ADDR_W`, 32: byte address width.
- `MAX_WAIT`, 8: consecutive cycles debug may be refused before a forced grant (guard only; legal range 1..255).

Ports:
- `clk` in 1: clock. Single clock domain.
- `areset_n` in 1: reset, asynchronous and active-low.
- `core_req_valid` in 1: core request present.
- `core_req_ready` out 1: core request accepted this cycle.
- `core_req_we` in 1: write when 1, read when 0.
- `core_req_addr` in `ADDR_W`: byte address.
- `core_req_wdata` in `XLEN`: write data.
- `core_req_be` in 4: byte enables.
- `core_rsp_valid` out 1: response pulse.
- `core_rsp_rdata` out `XLEN`: read data.
- `dbg_req_valid`, `dbg_req_ready`, `dbg_req_we`, `dbg_req_addr`, `dbg_req_wdata`, `dbg_req_be`, `dbg_rsp_valid`, `dbg_rsp_rdata`: identical set of ports for the debug requester.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `XLEN`: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_rdata` in `XLEN`: memory read data, valid one cycle after `mem_en`.

## Operation
- Grant is combinational from the current valids. An accept happens on `valid && ready`. `*_req_ready` may depend on `*_req_valid`.
- Default policy: core wins. `core_req_ready = core_req_valid`. `dbg_req_ready = dbg_req_valid && !core_req_valid`.
- The winning request drives `mem_*` in the same cycle with `mem_en=1`. With no accept, `mem_en=0` and the other `mem_*` outputs are 0.
- Registered `rsp_pending` and `rsp_owner` (core/dbg) capture each accept.
- On the next cycle the owner's `*_rsp_valid` pulses for exactly one cycle:
  - Reads: `*_rsp_rdata = mem_rdata`.
  - Writes: the ack carries `rdata = 0`.
  - The non-owner's `rsp_valid` stays 0 and its `rdata` stays 0.
- The arbiter is fully pipelined: a new accept may happen every cycle, back-to-back and alternating owners.
- Addresses, byte enables and data pass through unchanged. No alignment checking.

## Timing
- Reset (async assert, sync release): `rsp_pending=0`, both `rsp_valid=0`, both `rsp_rdata=0`, wait counter=0. While `areset_n=0`, both `ready=0` and `mem_en=0`.
- Latency: accept in cycle N, response in cycle N+1. Throughput is 1 access per cycle.
- Both valid in the same cycle: core is granted, except when a forced debug grant applies (guard only).
- Reset asserted mid-operation: the in-flight response is dropped, with no `rsp_valid` after release.
- Requesters must hold `valid` and payload stable until accepted. The arbiter does not buffer payloads.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - An 8-bit saturating counter increments each cycle with `dbg_req_valid && !dbg_req_ready`.
  - It clears on a debug accept or when `dbg_req_valid=0`.
  - When the counter equals `MAX_WAIT`, debug is granted that cycle regardless of core, and `core_req_ready=0`.
  - The counter resets to 0 after the forced accept.
- `DMEM_ARB_STARVE_GUARD_EN` not defined: strict core priority, no counter, `MAX_WAIT` is ignored. Debug can starve indefinitely.

## Structure
- `rv32i_pkg` gains:
  - `typedef enum logic {OWN_CORE, OWN_DBG} dmem_owner_e`
  - `typedef struct packed {we, addr, wdata, be} dmem_req_t`
  - localparam `DMEM_BE_W = 4`
- One sub-module, `dmem_arb_wait_counter`: the saturating starvation counter with clear and force-grant compare. It is instantiated only under the macro.

## Test plan
- Reset: hold `areset_n=0` with both valids high -> both `ready=0`, `mem_en=0`, `rsp_valid=0`. Release -> core accepted first cycle.
- Core read at 0x10 with the memory word there = 0xDEADBEEF -> `mem_en=1`, `mem_addr=0x10` in cycle N; `core_rsp_valid=1` with `rdata=0xDEADBEEF` in N+1 only; `dbg_rsp_valid=0`.
- Contention: both valid, core write 0x20←0x11223344, debug read 0x20 -> core first, debug accepted next cycle, debug reads back 0x11223344.
- Back-to-back alternating: core, dbg, core reads on consecutive cycles -> three responses on consecutive cycles, each routed to the correct owner.
- Guard (`DMEM_ARB_STARVE_GUARD_EN`, `MAX_WAIT=8`): core valid continuously, debug valid from cycle 0 -> `dbg_req_ready=1` in cycle 8 and `core_req_ready=0` in cycle 8. Without the macro, debug never granted in 50 cycles.
- Reset mid-flight: assert reset the cycle after a core read accept -> no `core_rsp_valid` after release; next access behaves normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dmem_arbiter_pkg
// Brief  : Shared widths, owner enum and request bundle for dmem_arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int DMEM_XLEN   = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_BE_W   = 4;
  localparam int DMEM_WAIT_W = 8;

  typedef enum logic {OWN_CORE, OWN_DBG} dmem_owner_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_XLEN-1:0]   wdata;
    logic [DMEM_BE_W-1:0]   be;
  } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dmem_arbiter_if
// Brief  : Core, debug and memory-side signals of the data-memory arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int XLEN   = dmem_arbiter_pkg::DMEM_XLEN,
  parameter int ADDR_W = dmem_arbiter_pkg::DMEM_ADDR_W
);
  localparam int BE_W = dmem_arbiter_pkg::DMEM_BE_W;

  logic              core_req_valid;
  logic              core_req_ready;
  logic              core_req_we;
  logic [ADDR_W-1:0] core_req_addr;
  logic [XLEN-1:0]   core_req_wdata;
  logic [BE_W-1:0]   core_req_be;
  logic              core_rsp_valid;
  logic [XLEN-1:0]   core_rsp_rdata;

  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic              dbg_req_we;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic [XLEN-1:0]   dbg_req_wdata;
  logic [BE_W-1:0]   dbg_req_be;
  logic              dbg_rsp_valid;
  logic [XLEN-1:0]   dbg_rsp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_be,
    output core_req_ready, core_rsp_valid, core_rsp_rdata,
    input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_req_be,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_be,
    input  core_req_ready, core_rsp_valid, core_rsp_rdata,
    output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_req_be,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_wait_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dmem_arb_wait_counter
// Brief  : Saturating count of refused debug cycles; flags a forced grant.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module dmem_arb_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  wire  clk,
  input  wire  areset_n,
  input  wire  dbg_req_valid,
  input  wire  dbg_req_accept,
  output logic force_grant
);

  localparam logic [DMEM_WAIT_W-1:0] C_MAX_WAIT = DMEM_WAIT_W'(MAX_WAIT);

  logic [DMEM_WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_wait_cnt <= '0;
    end else if (!dbg_req_valid || dbg_req_accept) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != '1) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // A stale count must not steal the slot once debug has withdrawn.
  assign force_grant = dbg_req_valid && (r_wait_cnt == C_MAX_WAIT);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dmem_arbiter
// Brief  : Core/debug arbiter for the single-port data memory, one-cycle
//          response routing. Optional starvation guard: DMEM_ARB_STARVE_GUARD_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN     = DMEM_XLEN,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input wire            clk,
  input wire            areset_n,
  dmem_arbiter_if.slave bus
);

  dmem_req_t   w_core_req;
  dmem_req_t   w_dbg_req;
  dmem_req_t   w_grant_req;
  logic        w_force_dbg;
  logic        w_core_accept;
  logic        w_dbg_accept;
  logic [XLEN-1:0] w_rsp_rdata;

  logic        r_rsp_pending;
  logic        r_rsp_we;
  dmem_owner_e r_rsp_owner;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk            (clk),
    .areset_n       (areset_n),
    .dbg_req_valid  (bus.dbg_req_valid),
    .dbg_req_accept (w_dbg_accept),
    .force_grant    (w_force_dbg)
  );
`else
  assign w_force_dbg = 1'b0;
`endif

  // Readiness is gated by the raw reset so nothing is accepted while held.
  assign w_core_accept = areset_n && bus.core_req_valid && !w_force_dbg;
  assign w_dbg_accept  = areset_n && bus.dbg_req_valid &&
                         (!bus.core_req_valid || w_force_dbg);

  assign bus.core_req_ready = w_core_accept;
  assign bus.dbg_req_ready  = w_dbg_accept;

  assign w_core_req = '{we:    bus.core_req_we,
                        addr:  DMEM_ADDR_W'(bus.core_req_addr),
                        wdata: DMEM_XLEN'(bus.core_req_wdata),
                        be:    bus.core_req_be};
  assign w_dbg_req  = '{we:    bus.dbg_req_we,
                        addr:  DMEM_ADDR_W'(bus.dbg_req_addr),
                        wdata: DMEM_XLEN'(bus.dbg_req_wdata),
                        be:    bus.dbg_req_be};

  always_comb begin
    w_grant_req = '0;
    if (w_core_accept) begin
      w_grant_req = w_core_req;
    end else if (w_dbg_accept) begin
      w_grant_req = w_dbg_req;
    end
  end

  assign bus.mem_en    = w_core_accept || w_dbg_accept;
  assign bus.mem_we    = w_grant_req.we;
  assign bus.mem_addr  = ADDR_W'(w_grant_req.addr);
  assign bus.mem_wdata = XLEN'(w_grant_req.wdata);
  assign bus.mem_be    = w_grant_req.be;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_rsp_pending <= 1'b0;
      r_rsp_we      <= 1'b0;
      r_rsp_owner   <= OWN_CORE;
    end else begin
      r_rsp_pending <= w_core_accept || w_dbg_accept;
      r_rsp_we      <= w_grant_req.we;
      r_rsp_owner   <= w_dbg_accept ? OWN_DBG : OWN_CORE;
    end
  end

  // Write acks carry zero data; read data comes straight from the memory.
  assign w_rsp_rdata = (r_rsp_pending && !r_rsp_we) ? bus.mem_rdata : '0;

  assign bus.core_rsp_valid = r_rsp_pending && (r_rsp_owner == OWN_CORE);
  assign bus.dbg_rsp_valid  = r_rsp_pending && (r_rsp_owner == OWN_DBG);
  assign bus.core_rsp_rdata = bus.core_rsp_valid ? w_rsp_rdata : '0;
  assign bus.dbg_rsp_rdata  = bus.dbg_rsp_valid  ? w_rsp_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_dmem_arbiter
// Brief  : Directed and random stimulus against a cycle-level reference of the
//          arbiter rules, with a word memory behind the arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk      = 1'b0;
  logic areset_n = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .XLEN     (32),
    .ADDR_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  bit          m_rsp_v;
  bit          m_rsp_dbg;
  logic [31:0] m_rsp_data;
  int          m_wait;

  bit          acc_c, acc_d, obs_crdy, obs_drdy, obs_c_rv, obs_d_rv;
  logic [31:0] obs_c_rdata, obs_d_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input bit v, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    bus.core_req_valid = v; bus.core_req_we = we; bus.core_req_addr = a;
    bus.core_req_wdata = wd; bus.core_req_be = be;
  endtask

  task automatic set_dbg(input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    bus.dbg_req_valid = v; bus.dbg_req_we = we; bus.dbg_req_addr = a;
    bus.dbg_req_wdata = wd; bus.dbg_req_be = be;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance memory and model.
  task automatic cycle();
    logic        exp_force, ec, ed, e_we, s_en, s_we, e_crv, e_drv;
    logic [31:0] e_addr, e_wd, s_addr, s_wd, old;
    logic [3:0]  e_be, s_be;
    int          idx;
    @(negedge clk);
    exp_force = GUARD && bus.dbg_req_valid && (m_wait == MAX_WAIT);
    ec = areset_n && bus.core_req_valid && !exp_force;
    ed = areset_n && bus.dbg_req_valid && (!bus.core_req_valid || exp_force);
    e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
    if (ec) begin
      e_we = bus.core_req_we; e_addr = bus.core_req_addr;
      e_wd = bus.core_req_wdata; e_be = bus.core_req_be;
    end else if (ed) begin
      e_we = bus.dbg_req_we; e_addr = bus.dbg_req_addr;
      e_wd = bus.dbg_req_wdata; e_be = bus.dbg_req_be;
    end
    e_crv = areset_n && m_rsp_v && !m_rsp_dbg;
    e_drv = areset_n && m_rsp_v && m_rsp_dbg;
    chk("core_req_ready", 32'(bus.core_req_ready), 32'(ec));
    chk("dbg_req_ready",  32'(bus.dbg_req_ready),  32'(ed));
    chk("mem_en",    32'(bus.mem_en), 32'(ec || ed));
    chk("mem_we",    32'(bus.mem_we), 32'(e_we));
    chk("mem_addr",  bus.mem_addr,  e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("mem_be",    32'(bus.mem_be), 32'(e_be));
    chk("core_rsp_valid", 32'(bus.core_rsp_valid), 32'(e_crv));
    chk("core_rsp_rdata", bus.core_rsp_rdata, e_crv ? m_rsp_data : 32'h0);
    chk("dbg_rsp_valid",  32'(bus.dbg_rsp_valid),  32'(e_drv));
    chk("dbg_rsp_rdata",  bus.dbg_rsp_rdata,  e_drv ? m_rsp_data : 32'h0);
    obs_crdy = bus.core_req_ready; obs_drdy = bus.dbg_req_ready;
    obs_c_rv = bus.core_rsp_valid; obs_d_rv = bus.dbg_rsp_valid;
    obs_c_rdata = bus.core_rsp_rdata; obs_d_rdata = bus.dbg_rsp_rdata;
    s_en = bus.mem_en; s_we = bus.mem_we; s_addr = bus.mem_addr;
    s_wd = bus.mem_wdata; s_be = bus.mem_be;
    @(posedge clk);
    if (s_en) begin
      idx = int'(s_addr[7:2]);
      old = mem[idx];
      if (s_we) mem[idx] = merge(old, s_wd, s_be);
      bus.mem_rdata = old;
    end else begin
      bus.mem_rdata = $urandom;
    end
    if (!areset_n) begin
      m_rsp_v = 1'b0; m_wait = 0;
    end else begin
      m_rsp_v = ec || ed; m_rsp_dbg = ed; m_rsp_data = '0;
      if (ec || ed) begin
        idx = int'(e_addr[7:2]);
        if (e_we) ref_mem[idx] = merge(ref_mem[idx], e_wd, e_be);
        else      m_rsp_data = ref_mem[idx];
      end
      if (!bus.dbg_req_valid || ed) m_wait = 0;
      else if (m_wait < 255)        m_wait++;
    end
    acc_c = ec; acc_d = ed;
    #1;
  endtask

  task automatic rand_core(input bit allow_write);
    set_core(1'b1, allow_write ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic rand_dbg();
    set_dbg(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
  endtask

  initial begin
    int grant;
    bit core_at_grant;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hC0DE0000 + 32'(i);
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    m_rsp_v = 1'b0; m_rsp_dbg = 1'b0; m_rsp_data = '0; m_wait = 0;
    bus.mem_rdata = '0;
    set_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_dbg(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    #1 areset_n = 1'b0;

    // Reset held with both valids up, then core wins the first free cycle.
    repeat (2) cycle();
    chk("reset_core_ready", 32'(obs_crdy), 32'h0);
    areset_n = 1'b1;
    cycle();
    chk("post_reset_core_first", 32'(obs_crdy), 32'h1);
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("core_read_deadbeef", obs_c_rdata, 32'hDEADBEEF);
    chk("dbg_idle_during_core_rsp", 32'(obs_d_rv), 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    // Contention: core write wins, debug read of the same word follows.
    set_core(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
    set_dbg(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    cycle();
    chk("contention_core_first", 32'(obs_crdy && !obs_drdy), 32'h1);
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("contention_dbg_next", 32'(obs_drdy), 32'h1);
    chk("core_write_ack_zero", obs_c_rdata, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("dbg_readback", obs_d_rdata, 32'h11223344);

    // Back-to-back alternating owners.
    set_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    cycle();
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_dbg(1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
    cycle();
    chk("alt_core_rsp", obs_c_rdata, 32'hDEADBEEF);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_core(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    cycle();
    chk("alt_dbg_rsp", obs_d_rdata, 32'hC0DE0009);
    chk("alt_core_quiet", 32'(obs_c_rv), 32'h0);
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("alt_core_rsp2", obs_c_rdata, 32'h11223344);

    // Starvation: core reads continuously while debug waits.
    rand_core(1'b0);
    set_dbg(1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    grant = -1;
    core_at_grant = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (obs_drdy && grant < 0) begin
        grant = k;
        core_at_grant = obs_crdy;
      end
      if (acc_d) set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (acc_c) rand_core(1'b0);
    end
    chk("starve_grant_cycle", 32'(grant), GUARD ? 32'd8 : 32'hFFFFFFFF);
    chk("starve_core_blocked", 32'(core_at_grant), GUARD ? 32'h0 : 32'h1);
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    // Reset the cycle after a core read accept drops its response.
    set_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    cycle();
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    areset_n = 1'b0;
    cycle();
    chk("midflight_drop", 32'(obs_c_rv), 32'h0);
    areset_n = 1'b1;
    cycle();
    chk("midflight_after_release", 32'(obs_c_rv), 32'h0);
    set_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    cycle();
    set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("post_midflight_read", obs_c_rdata, 32'hDEADBEEF);

    // Random traffic with requesters holding until accepted, occasional reset.
    for (int n = 0; n < 400; n++) begin
      if (acc_c || !bus.core_req_valid) begin
        if ($urandom_range(0, 3) != 0) rand_core(1'b1);
        else set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      if (acc_d || !bus.dbg_req_valid) begin
        if ($urandom_range(0, 1) != 0) rand_dbg();
        else set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      areset_n = ($urandom_range(0, 49) != 0);
      cycle();
    end
    areset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
